switch_change_encoder: RTL and testbench

- Front end of the memory-light game datapath, directly upstream of the level/lighting sequencer.
- Synchronises and debounces the raw slide switches, then detects each settled toggle.
- Buffers toggles as a pending bitmask and presents the lowest pending switch index as a 4-bit change code, holding it until the sequencer acknowledges.
- When nothing is pending, the output is the idle code 4'b1111.

---
 rtl/switch_change_encoder_pkg.sv | 10 +
 rtl/switch_change_encoder_debouncer.sv | 39 +++
 rtl/switch_change_encoder.sv | 97 +++++++++
 tb/tb_switch_change_encoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_change_encoder_pkg.sv
// rtl/switch_change_encoder_pkg.sv - shared change-code constants and FSM states
package switch_change_encoder_pkg;
   localparam int SW_CODE_W = 4;
   localparam logic [SW_CODE_W-1:0] IDLE_CODE = 4'b1111;

   typedef enum logic {
      ARM = 1'b0,
      RUN = 1'b1
   } state_t;
endpackage

// File: rtl/switch_change_encoder_debouncer.sv
// rtl/switch_change_encoder_debouncer.sv - per-switch synchroniser, debouncer and toggle pulse
module sw_debouncer #(
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic sw,
   output logic toggle,
   output logic quiet
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic [1:0]    sync;
   logic          settled;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync    <= '0;
         settled <= 1'b0;
         cnt     <= '0;
         toggle  <= 1'b0;
      end else begin
         sync   <= {sync[0], sw};
         toggle <= 1'b0;
         if (sync[1] == settled) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            settled <= sync[1];
            cnt     <= '0;
            toggle  <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign quiet = (sync[1] == settled) && (cnt == '0);
endmodule

// File: rtl/switch_change_encoder.sv
// rtl/switch_change_encoder.sv - debounced switch toggles buffered and reported as a change code
module switch_change_encoder
   import switch_change_encoder_pkg::*;
#(
   parameter int NUM_SW          = 10,
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_SW-1:0]    sw,
   input  logic                 enable,
   input  logic                 ack,
   input  logic                 clear,
   output logic [SW_CODE_W-1:0] change,
   output logic [3:0]           pending_cnt,
   output logic                 overflow
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic [NUM_SW-1:0]    toggle, quiet, rec, mask_q, mask_n;
   logic [SW_CODE_W-1:0] code_n;
   logic [3:0]           cnt_n;
   logic                 ovf_n, ack_hit, all_quiet, arm_done;
   logic [CW-1:0]        arm_cnt;
   state_t               state_q, state_n;

   for (genvar g = 0; g < NUM_SW; g++) begin : g_deb
      sw_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk    (clk),
         .reset  (reset),
         .sw     (sw[g]),
         .toggle (toggle[g]),
         .quiet  (quiet[g])
      );
   end

   // Power-up positions are absorbed in ARM until every input has been quiet for a full window
   assign all_quiet = &quiet;
   assign arm_done  = all_quiet && (arm_cnt == CW'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARM;
         arm_cnt <= '0;
      end else begin
         state_q <= state_n;
         arm_cnt <= (state_q == ARM && all_quiet && !arm_done) ? arm_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      state_n = state_q;
      if (state_q == ARM && arm_done) state_n = RUN;
   end

   always_comb begin
      mask_n  = mask_q;
      ovf_n   = overflow;
      ack_hit = ack && (change != IDLE_CODE);
      rec     = (state_q == RUN && enable) ? toggle : '0;
      if (clear) begin
         mask_n = '0;
         ovf_n  = 1'b0;
      end else begin
         for (int i = 0; i < NUM_SW; i++) begin
            if (ack_hit && change == SW_CODE_W'(i)) mask_n[i] = 1'b0;
            if (rec[i]) begin
               if (mask_q[i] && !(ack_hit && change == SW_CODE_W'(i))) ovf_n = 1'b1;
               else mask_n[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      code_n = IDLE_CODE;
      cnt_n  = '0;
      for (int i = NUM_SW - 1; i >= 0; i--) begin
         if (mask_n[i]) code_n = SW_CODE_W'(i);
      end
      for (int i = 0; i < NUM_SW; i++) cnt_n = cnt_n + 4'(mask_n[i]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q      <= '0;
         change      <= IDLE_CODE;
         pending_cnt <= '0;
         overflow    <= 1'b0;
      end else begin
         mask_q      <= mask_n;
         change      <= code_n;
         pending_cnt <= cnt_n;
         overflow    <= ovf_n;
      end
   end
endmodule

// File: tb/tb_switch_change_encoder.sv
// tb/tb_switch_change_encoder.sv - scoreboard bench for switch_change_encoder
module tb_switch_change_encoder;
   import switch_change_encoder_pkg::*;

   localparam int NUM_SW = 10;
   localparam int DB     = 20;
   localparam logic [8:0] IDLE_T = {4'hF, 4'd0, 1'b0};

   logic              clk, reset, enable, ack, clear;
   logic [NUM_SW-1:0] sw;
   logic [3:0]        change, pending_cnt;
   logic              overflow;

   int errors = 0;
   int checks = 0;

   switch_change_encoder dut (
      .clk         (clk),
      .reset       (reset),
      .sw          (sw),
      .enable      (enable),
      .ack         (ack),
      .clear       (clear),
      .change      (change),
      .pending_cnt (pending_cnt),
      .overflow    (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: sample history, run lengths of disagreement, a pending set
   bit [NUM_SW-1:0] m_d1, m_d2, m_settled, m_fire, m_mask;
   int              m_run [NUM_SW];
   bit              m_ovf, m_is_run;
   int              m_qrun;
   logic [8:0]      m_prev;
   logic [8:0]      exp_q [$];
   logic [8:0]      mon_last;

   function automatic int lowest(bit [NUM_SW-1:0] m);
      for (int i = 0; i < NUM_SW; i++) if (m[i]) return i;
      return 15;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_loop();
      bit [NUM_SW-1:0] nm;
      bit              all_q, ack_hit;
      int              cur;
      logic [8:0]      e;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_d1 = '0; m_d2 = '0; m_settled = '0; m_fire = '0; m_mask = '0;
            foreach (m_run[i]) m_run[i] = 0;
            m_ovf = 0; m_is_run = 0; m_qrun = 0;
            exp_q.delete();
            m_prev = IDLE_T;
         end else begin
            all_q = 1;
            for (int i = 0; i < NUM_SW; i++)
               if (m_d2[i] != m_settled[i] || m_run[i] != 0) all_q = 0;
            cur = lowest(m_mask);
            ack_hit = ack && cur != 15;
            if (clear) begin
               m_mask = '0;
               m_ovf = 0;
            end else begin
               nm = m_mask;
               if (ack_hit) nm[cur] = 0;
               if (m_is_run && enable)
                  for (int i = 0; i < NUM_SW; i++)
                     if (m_fire[i]) begin
                        if (m_mask[i] && !(ack_hit && cur == i)) m_ovf = 1;
                        else nm[i] = 1;
                     end
               m_mask = nm;
            end
            for (int i = 0; i < NUM_SW; i++) begin
               m_fire[i] = 0;
               if (m_d2[i] != m_settled[i]) begin
                  m_run[i]++;
                  if (m_run[i] == DB) begin
                     m_settled[i] = m_d2[i];
                     m_run[i] = 0;
                     m_fire[i] = 1;
                  end
               end else m_run[i] = 0;
            end
            m_d2 = m_d1;
            m_d1 = sw;
            if (!m_is_run) begin
               if (all_q) begin
                  m_qrun++;
                  if (m_qrun == DB) m_is_run = 1;
               end else m_qrun = 0;
            end
            e = {4'(lowest(m_mask)), 4'($countones(m_mask)), m_ovf};
            if (e != m_prev) begin
               exp_q.push_back(e);
               m_prev = e;
            end
         end
      end
   endtask

   task automatic monitor_loop();
      logic [8:0] act, e;
      forever begin
         @(negedge clk);
         act = {change, pending_cnt, overflow};
         if (reset) mon_last = IDLE_T;
         else if (act !== mon_last) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard: got %h with nothing expected", act);
            end else begin
               e = exp_q.pop_front();
               if (e !== act) begin
                  errors++;
                  $display("FAIL scoreboard: got chg=%0d cnt=%0d ovf=%0d expected chg=%0d cnt=%0d ovf=%0d",
                           act[8:5], act[4:1], act[0], e[8:5], e[4:1], e[0]);
               end
            end
            mon_last = act;
         end
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
   endtask

   task automatic wait_run(string name);
      int n = 0;
      while (!m_is_run && n < 300) begin
         tick(1);
         n++;
      end
      chk({name, "_arm_timeout"}, int'(m_is_run), 1);
      chk({name, "_state_run"}, int'(dut.state_q), int'(RUN));
   endtask

   initial begin
      int k;
      mon_last = IDLE_T;
      reset = 1'b0; sw = 10'h005; enable = 1'b1; ack = 1'b0; clear = 1'b0;
      fork
         model_loop();
         monitor_loop();
      join_none
      #1 reset = 1'b1;
      #1;
      chk("rst_change", int'(change), 15);
      chk("rst_cnt", int'(pending_cnt), 0);
      chk("rst_ovf", int'(overflow), 0);
      tick(3);
      reset = 1'b0;
      wait_run("boot");
      chk("boot_change", int'(change), 15);
      chk("boot_cnt", int'(pending_cnt), 0);

      sw[3] = 1'b1;
      tick(22);
      chk("lat_early", int'(change), 15);
      tick(1);
      chk("lat_change", int'(change), 3);
      chk("lat_cnt", int'(pending_cnt), 1);
      do_ack();
      chk("ack_idle", int'(change), 15);

      sw[7] = 1'b1; tick(19); sw[7] = 1'b0; tick(40);
      chk("glitch19", int'(change), 15);
      sw[7] = 1'b1; tick(20); sw[7] = 1'b0; tick(3);
      chk("pulse20_rise", int'(change), 7);
      do_ack();
      tick(25);
      chk("pulse20_fall", int'(change), 7);
      do_ack();

      sw = sw ^ 10'h224;
      tick(23);
      chk("multi_2", int'(change), 2);
      chk("multi_cnt3", int'(pending_cnt), 3);
      do_ack();
      chk("multi_5", int'(change), 5);
      chk("multi_cnt2", int'(pending_cnt), 2);
      do_ack();
      chk("multi_9", int'(change), 9);
      chk("multi_cnt1", int'(pending_cnt), 1);
      do_ack();
      chk("multi_idle", int'(change), 15);
      chk("multi_cnt0", int'(pending_cnt), 0);

      sw[4] = ~sw[4]; tick(30); sw[4] = ~sw[4]; tick(30);
      chk("ovf_set", int'(overflow), 1);
      chk("ovf_cnt", int'(pending_cnt), 1);
      clear = 1'b1; tick(1); clear = 1'b0;
      chk("clr_ovf", int'(overflow), 0);
      chk("clr_change", int'(change), 15);

      enable = 1'b0; sw[1] = ~sw[1]; tick(30); enable = 1'b1;
      chk("dis_change", int'(change), 15);
      chk("dis_cnt", int'(pending_cnt), 0);
      sw[8] = ~sw[8]; tick(25);
      chk("pre_rst_change", int'(change), 8);
      sw[6] = ~sw[6]; tick(10);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_change", int'(change), 15);
      chk("mid_rst_cnt", int'(pending_cnt), 0);
      chk("mid_rst_ovf", int'(overflow), 0);
      chk("mid_rst_arm", int'(dut.state_q), int'(ARM));
      tick(2);
      reset = 1'b0;
      wait_run("rearm");

      repeat (3000) begin
         tick(1);
         ack   = ($urandom_range(5) == 0);
         clear = ($urandom_range(299) == 0);
         if ($urandom_range(149) == 0) enable = ~enable;
         if ($urandom_range(15) == 0) begin
            k = $urandom_range(NUM_SW - 1);
            sw[k] = ~sw[k];
         end
      end
      enable = 1'b1; clear = 1'b0; ack = 1'b1;
      tick(80);
      ack = 1'b0;
      tick(2);
      chk("drain_change", int'(change), 15);
      chk("drain_queue", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
